ser_rx_deframer: RTL

- Serial receive stage directly downstream of the psi serial output.
- Consumes the LSB-first bit stream and its framing: idle 0s, SOF dword 32'h5a5a5a5a, N data dwords, then a 48-bit EOF made of 32'h0f0f0f0f followed by 16'h0f0f.
- Recovers the data dwords and marks the last dword of each frame.
- Buffers recovered dwords in a small FIFO and presents them on a valid/ready parallel interface for loopback checking and for the receive-side DMA.

---
 rtl/ser_rx_deframer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/ser_rx_deframer.sv
// ser_rx_deframer
//   Serial receive deframer. Hunts for the start-of-frame dword in an
//   LSB-first bit stream, recovers the data dwords up to the end-of-frame
//   marker (EOF dword + tail half-word), and queues them with a last flag
//   in a small output FIFO behind a valid/ready interface.
//
// Ports
//   s_clk      serial clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   s_data     serial bit, LSB first
//   out_data   recovered dword at FIFO head
//   out_last   head dword closes its frame
//   out_valid  FIFO not empty
//   out_ready  consumer accepts the head dword
//   busy       receiver is inside a frame
//   frame_cnt  completed non-empty frames (wraps)
//   err_ovf    sticky: a push was dropped on a full FIFO
//   err_empty  one-cycle pulse on a frame with no data dwords
//
// State | meaning
// HUNT  | bit-level search for SOF_PAT in the shift register
// DATA  | assembling a 32-bit dword
// TAIL  | EOF_PAT seen, assembling the 16-bit tail to confirm end of frame
module ser_rx_deframer #(
  parameter int          DSIZE    = 32,
  parameter int          ASIZE    = 2,
  parameter logic [31:0] SOF_PAT  = 32'h5a5a5a5a,
  parameter logic [31:0] EOF_PAT  = 32'h0f0f0f0f,
  parameter logic [15:0] TAIL_PAT = 16'h0f0f
) (
  input  logic             s_clk,
  input  logic             rst,
  input  logic             s_data,
  output logic [DSIZE-1:0] out_data,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [15:0]      frame_cnt,
  output logic             err_ovf,
  output logic             err_empty
);

  localparam int DEPTH = 1 << ASIZE;

  typedef enum logic [1:0] {HUNT, DATA, TAIL} state_t;

  state_t           state, state_nxt;
  logic [31:0]      sr, sr_shift, sr_nxt;
  logic [4:0]       bit_cnt, bit_cnt_nxt;
  logic [DSIZE-1:0] hold, hold_nxt;
  logic             hold_valid, hold_valid_nxt;
  logic             push;
  logic [DSIZE:0]   push_entry;
  logic             frame_done;
  logic             empty_frame;

  logic [DSIZE:0]   mem [DEPTH];
  logic [ASIZE-1:0] wr_ptr, rd_ptr;
  logic [ASIZE:0]   count;
  logic             pop, full, push_ok;

  always_comb begin
    sr_shift       = {s_data, sr[31:1]};
    state_nxt      = state;
    sr_nxt         = sr_shift;
    bit_cnt_nxt    = bit_cnt + 5'd1;
    hold_nxt       = hold;
    hold_valid_nxt = hold_valid;
    push           = 1'b0;
    push_entry     = {1'b0, hold};
    frame_done     = 1'b0;
    empty_frame    = 1'b0;
    case (state)
      HUNT: begin
        bit_cnt_nxt = '0;
        if (sr_shift == SOF_PAT) begin
          state_nxt      = DATA;
          hold_valid_nxt = 1'b0;
        end
      end
      DATA: begin
        if (bit_cnt == 5'd31) begin
          bit_cnt_nxt = '0;
          if (sr_shift == EOF_PAT) begin
            state_nxt = TAIL;
          end else begin
            // one-dword holdback: the previous dword is known not to be last
            push           = hold_valid;
            hold_nxt       = sr_shift;
            hold_valid_nxt = 1'b1;
          end
        end
      end
      TAIL: begin
        if (bit_cnt == 5'd15) begin
          if (sr_shift[31:16] == TAIL_PAT) begin
            state_nxt      = HUNT;
            sr_nxt         = '0;   // keep marker bits from aliasing into a false SOF
            bit_cnt_nxt    = '0;
            hold_valid_nxt = 1'b0;
            if (hold_valid) begin
              push       = 1'b1;
              push_entry = {1'b1, hold};
              frame_done = 1'b1;
            end else begin
              empty_frame = 1'b1;
            end
          end else begin
            // EOF_PAT was really data; the 16 bits already in sr are the
            // low half of the following dword
            push           = hold_valid;
            hold_nxt       = EOF_PAT;
            hold_valid_nxt = 1'b1;
            state_nxt      = DATA;
            bit_cnt_nxt    = 5'd16;
          end
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  always_ff @(posedge s_clk) begin
    if (rst) begin
      state      <= HUNT;
      sr         <= '0;
      bit_cnt    <= '0;
      hold       <= '0;
      hold_valid <= 1'b0;
      frame_cnt  <= '0;
      err_empty  <= 1'b0;
    end else begin
      state      <= state_nxt;
      sr         <= sr_nxt;
      bit_cnt    <= bit_cnt_nxt;
      hold       <= hold_nxt;
      hold_valid <= hold_valid_nxt;
      err_empty  <= empty_frame;
      if (frame_done) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  assign busy = (state != HUNT);

  // output FIFO; count reaches exactly DEPTH so its MSB is the full flag
  assign out_valid = (count != '0);
  assign full      = count[ASIZE];
  assign pop       = out_valid && out_ready;
  assign push_ok   = push && (!full || pop);
  assign {out_last, out_data} = mem[rd_ptr];

  always_ff @(posedge s_clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      err_ovf <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + ASIZE'(1);
      end
      if (pop) rd_ptr <= rd_ptr + ASIZE'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (ASIZE+1)'(1);
        2'b01:   count <= count - (ASIZE+1)'(1);
        default: count <= count;
      endcase
      if (push && !push_ok) err_ovf <= 1'b1;
    end
  end

endmodule
